puf_clear_responder: RTL and testbench



---
 rtl/puf_clear_responder_if.sv | 29 ++
 rtl/puf_clear_responder.sv | 161 ++++++++++++++++
 tb/tb_puf_clear_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/puf_clear_responder_if.sv
// Clear-request handshake, slot-bank write port and read-back port of the PUF clear responder.
interface puf_clear_responder_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic              clr;
    logic              clr_done;
    logic              busy;
    logic              osc_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              resp_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              clr_err;

    modport master (
        output clr, rd_data,
        input  clr_done, busy, osc_en, wr_en, wr_addr, wr_data,
               resp_valid, rd_addr, clr_err
    );

    modport slave (
        input  clr, rd_data,
        output clr_done, busy, osc_en, wr_en, wr_addr, wr_data,
               resp_valid, rd_addr, clr_err
    );
endinterface

// File: rtl/puf_clear_responder.sv
// Clear responder: halt oscillators, settle, wipe the response bank, pulse clr_done.
// Optional read-back verify of the wiped bank is enabled by defining PUF_CLR_VERIFY_EN.
module puf_clear_responder #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16,
    parameter int SETTLE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    puf_clear_responder_if.slave   bus
);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, HALT, WIPE, VERIFY, VDRAIN, DONE} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nx;
    logic              wr_en, wr_en_nx;
    logic              osc_en, osc_en_nx;
    logic              busy, busy_nx;
    logic              clr_done, clr_done_nx;
    logic              resp_valid, resp_valid_nx;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nx;
    logic              chk, chk_nx;
    logic              clr_err, clr_err_nx;

    // State register plus all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_addr    <= '0;
            wr_en      <= 1'b0;
            osc_en     <= 1'b0;
            busy       <= 1'b0;
            clr_done   <= 1'b0;
            resp_valid <= 1'b0;
            rd_addr    <= '0;
            chk        <= 1'b0;
            clr_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            wr_addr    <= wr_addr_nx;
            wr_en      <= wr_en_nx;
            osc_en     <= osc_en_nx;
            busy       <= busy_nx;
            clr_done   <= clr_done_nx;
            resp_valid <= resp_valid_nx;
            rd_addr    <= rd_addr_nx;
            chk        <= chk_nx;
            clr_err    <= clr_err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.clr) state_nx = HALT;
            HALT: if (cnt == LAST_CNT) state_nx = WIPE;
            WIPE: if (wr_addr == LAST_ADDR) begin
`ifdef PUF_CLR_VERIFY_EN
                state_nx = VERIFY;
`else
                state_nx = DONE;
`endif
            end
`ifdef PUF_CLR_VERIFY_EN
            VERIFY: if (rd_addr == LAST_ADDR) state_nx = VDRAIN;
            VDRAIN: state_nx = DONE;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_nx        = cnt;
        wr_addr_nx    = wr_addr;
        wr_en_nx      = 1'b0;
        osc_en_nx     = 1'b0;
        busy_nx       = 1'b1;
        clr_done_nx   = 1'b0;
        resp_valid_nx = resp_valid;
        rd_addr_nx    = rd_addr;
        chk_nx        = 1'b0;
        // rd_data answers the address presented one cycle earlier
        clr_err_nx    = clr_err | (chk && (bus.rd_data != '0));
        case (state)
            IDLE: begin
                osc_en_nx = 1'b1;
                busy_nx   = 1'b0;
                if (bus.clr) begin
                    osc_en_nx     = 1'b0;
                    busy_nx       = 1'b1;
                    resp_valid_nx = 1'b0;
                    cnt_nx        = '0;
                    clr_err_nx    = 1'b0;
                end
            end
            HALT: begin
                if (cnt == LAST_CNT) begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WIPE: begin
                if (wr_addr == LAST_ADDR) begin
                    wr_addr_nx = '0;
`ifndef PUF_CLR_VERIFY_EN
                    clr_done_nx = 1'b1;
`endif
                end else begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = wr_addr + 1'b1;
                end
            end
`ifdef PUF_CLR_VERIFY_EN
            VERIFY: begin
                chk_nx     = 1'b1;
                rd_addr_nx = (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
            end
            VDRAIN: clr_done_nx = 1'b1;
`endif
            DONE: begin
                osc_en_nx = 1'b1;
                busy_nx   = 1'b0;
`ifdef PUF_CLR_VERIFY_EN
                resp_valid_nx = ~clr_err;
`else
                resp_valid_nx = 1'b1;
`endif
            end
            default: begin
                osc_en_nx = 1'b1;
                busy_nx   = 1'b0;
            end
        endcase
    end

    assign bus.clr_done   = clr_done;
    assign bus.busy       = busy;
    assign bus.osc_en     = osc_en;
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = '0;
    assign bus.resp_valid = resp_valid;
`ifdef PUF_CLR_VERIFY_EN
    assign bus.rd_addr    = rd_addr;
    assign bus.clr_err    = clr_err;
`else
    assign bus.rd_addr    = '0;
    assign bus.clr_err    = 1'b0;
`endif
endmodule

// File: tb/tb_puf_clear_responder.sv
// Directed bench for puf_clear_responder with a small response-bank model.
module tb_puf_clear_responder;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int SETTLE = 4;
`ifdef PUF_CLR_VERIFY_EN
    localparam int LAT = 22;
`else
    localparam int LAT = 13;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    puf_clear_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    puf_clear_responder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [DATA_W-1:0] bank [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              fill;
    logic              stuck6;

    // Bank model; slot 6 can be made to hold a stuck bit
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= DATA_W'(16'hA5A0 + i);
        end else if (bus.wr_en) begin
            bank[bus.wr_addr] <= (stuck6 && bus.wr_addr == 3'd6) ? 16'h0001 : bus.wr_data;
        end
        rd_q <= bank[bus.rd_addr];
    end
    assign bus.rd_data = rd_q;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {clr_done, busy, osc_en, wr_en, wr_addr[2:0], resp_valid}
    function automatic logic [7:0] obs();
        return {bus.clr_done, bus.busy, bus.osc_en, bus.wr_en, bus.wr_addr, bus.resp_valid};
    endfunction

    // k counts cycles after the IDLE cycle that sampled clr
    function automatic logic [7:0] exp_vec(input int k, input logic rv_end);
        if (k <= SETTLE)         return 8'h40;
        if (k <= SETTLE + DEPTH) return {4'b0101, 3'(k - SETTLE - 1), 1'b0};
        if (k < LAT)             return 8'h40;
        if (k == LAT)            return 8'hC0;
        return {7'b0010000, rv_end};
    endfunction

    task automatic run_clear(input logic keep, input logic pulse, input logic rv_end);
        bus.clr = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check($sformatf("seq k=%0d", k), 32'(obs()), 32'(exp_vec(k, rv_end)));
            if (k > SETTLE && k <= SETTLE + DEPTH)
                check("wr_data", 32'(bus.wr_data), 32'd0);
`ifdef PUF_CLR_VERIFY_EN
            if (k > SETTLE + DEPTH && k <= SETTLE + 2 * DEPTH)
                check("rd_addr", 32'(bus.rd_addr), 32'(k - SETTLE - DEPTH - 1));
`endif
            if (pulse && k == 1)          bus.clr = 1'b0;
            if (pulse && k == SETTLE + 4) bus.clr = 1'b1;
            if (pulse && k == SETTLE + 5) bus.clr = 1'b0;
        end
        bus.clr = keep;
        tick();
        check("post", 32'(obs()), 32'(exp_vec(LAT + 1, rv_end)));
    endtask

    initial begin
        rst    = 1'b1;
        bus.clr = 1'b0;
        fill   = 1'b1;
        stuck6 = 1'b0;
        repeat (3) tick();
        check("rst_vec", 32'(obs()), 32'h00);
        check("rst_rd", 32'({bus.rd_addr, bus.clr_err}), 32'h0);
        fill = 1'b0;
        rst  = 1'b0;
        tick();
        check("osc_up", 32'(obs()), 32'h20);
        repeat (3) begin
            tick();
            check("idle", 32'(obs()), 32'h20);
        end

        // single clear, then every slot must read zero
        run_clear(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) check($sformatf("bank%0d", i), 32'(bank[i]), 32'h0);
        tick();
        check("idle_rv", 32'(obs()), 32'h21);

        // back-to-back: clr held through clr_done
        run_clear(1'b1, 1'b0, 1'b1);
        run_clear(1'b0, 1'b0, 1'b1);

        // clr pulse at wr_addr=3 ignored
        fill = 1'b1;
        tick();
        fill = 1'b0;
        run_clear(1'b0, 1'b1, 1'b1);
        repeat (5) begin
            tick();
            check("no_restart", 32'(obs()), 32'h21);
        end
        for (int i = 0; i < DEPTH; i++) check($sformatf("bank_p%0d", i), 32'(bank[i]), 32'h0);

        // reset mid-wipe at wr_addr=5
        fill = 1'b1;
        tick();
        fill = 1'b0;
        bus.clr = 1'b1;
        for (int k = 1; k <= SETTLE + 6; k++) begin
            tick();
            check($sformatf("mid k=%0d", k), 32'(obs()), 32'(exp_vec(k, 1'b1)));
        end
        rst = 1'b1;
        bus.clr = 1'b0;
        tick();
        check("rst_mid", 32'(obs()), 32'h00);
        rst = 1'b0;
        tick();
        check("rst_mid_idle", 32'(obs()), 32'h20);
        repeat (4) begin
            tick();
            check("rst_mid_quiet", 32'(obs()), 32'h20);
        end
        check("part5", 32'(bank[5]), 32'h0);
        check("part6", 32'(bank[6]), 32'hA5A6);
        check("part7", 32'(bank[7]), 32'hA5A7);

`ifdef PUF_CLR_VERIFY_EN
        // stuck bit at slot 6: error flagged, bank not declared valid
        stuck6 = 1'b1;
        run_clear(1'b0, 1'b0, 1'b0);
        check("clr_err", 32'(bus.clr_err), 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
